// File: rtl/fir_tap_buffer.sv
// Tap delay line for a FIR filter: shifts accepted samples into TAPS registers and flags full tap vectors.
// Optional decimation of the out_valid strobe is enabled by defining FIR_TAP_BUFFER_DECIM_EN.
module fir_tap_buffer #(
    parameter int DATA_W = 8,
    parameter int TAPS   = 8,
    parameter int DECIM  = 2
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        enable,
    input  logic                        flush,
    input  logic                        in_valid,
    input  logic [DATA_W-1:0]           in_data,
    output logic                        in_ready,
    output logic [TAPS*DATA_W-1:0]      taps,
    output logic [$clog2(TAPS+1)-1:0]   fill,
    output logic                        primed,
    output logic                        out_valid
);

    localparam int FILL_W = $clog2(TAPS + 1);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        PRIMED  = 2'd2
    } state_t;

    if (DATA_W < 1 || DATA_W > 32) begin : g_bad_data_w
        $error("fir_tap_buffer: DATA_W must be in 1..32");
    end
    if (TAPS < 2 || TAPS > 64) begin : g_bad_taps
        $error("fir_tap_buffer: TAPS must be in 2..64");
    end
    if (DECIM < 1 || DECIM > 16) begin : g_bad_decim
        $error("fir_tap_buffer: DECIM must be in 1..16");
    end

    state_t              state;
    logic [DATA_W-1:0]   tap_q [TAPS];
    logic                accept;
    logic                primed_accept;

`ifdef FIR_TAP_BUFFER_DECIM_EN
    localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    logic [PH_W-1:0]     phase;
`endif

    assign in_ready = enable & ~flush & resetn;
    assign accept   = in_valid & in_ready;

    // An accept "leaves the state PRIMED" either when already primed or when it supplies the last missing tap.
    assign primed_accept = accept &&
                           ((state == PRIMED) ||
                            (state == FILLING && fill == FILL_W'(TAPS - 1)));

    assign primed = (state == PRIMED);

    for (genvar k = 0; k < TAPS; k++) begin : g_taps_out
        assign taps[k*DATA_W +: DATA_W] = tap_q[k];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < TAPS; k++) begin
                tap_q[k] <= '0;
            end
            fill      <= '0;
            state     <= EMPTY;
            out_valid <= 1'b0;
`ifdef FIR_TAP_BUFFER_DECIM_EN
            phase     <= '0;
`endif
        end else if (flush) begin
            for (int k = 0; k < TAPS; k++) begin
                tap_q[k] <= '0;
            end
            fill      <= '0;
            state     <= EMPTY;
            out_valid <= 1'b0;
`ifdef FIR_TAP_BUFFER_DECIM_EN
            phase     <= '0;
`endif
        end else begin
            out_valid <= 1'b0;
            if (accept) begin
                for (int k = TAPS - 1; k > 0; k--) begin
                    tap_q[k] <= tap_q[k-1];
                end
                tap_q[0] <= in_data;

                if (fill != FILL_W'(TAPS)) begin
                    fill <= fill + 1'b1;
                end

                case (state)
                    EMPTY:   state <= FILLING;
                    FILLING: if (fill == FILL_W'(TAPS - 1)) state <= PRIMED;
                    PRIMED:  state <= PRIMED;
                    default: state <= EMPTY;
                endcase
            end

            // The strobe is raised only on the first of every DECIM primed accepts when decimating.
            if (primed_accept) begin
`ifdef FIR_TAP_BUFFER_DECIM_EN
                out_valid <= (phase == '0);
                if (phase == PH_W'(DECIM - 1)) begin
                    phase <= '0;
                end else begin
                    phase <= phase + 1'b1;
                end
`else
                out_valid <= 1'b1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_fir_tap_buffer.sv
// Randomised and directed bench for fir_tap_buffer against a queue-based reference model.
// Define FIR_TAP_BUFFER_DECIM_EN for both files to check the decimated build.
module tb_fir_tap_buffer;

    localparam int DATA_W = 8;
    localparam int TAPS   = 8;
    localparam int DECIM  = 2;
    localparam int FILL_W = $clog2(TAPS + 1);

    logic                     clk = 1'b0;
    bit                       clk_run = 1'b0;
    logic                     resetn;
    logic                     enable;
    logic                     flush;
    logic                     in_valid;
    logic [DATA_W-1:0]        in_data;
    logic                     in_ready;
    logic [TAPS*DATA_W-1:0]   taps;
    logic [FILL_W-1:0]        fill;
    logic                     primed;
    logic                     out_valid;

    int total = 0;
    int bad = 0;
    int pulse_cnt = 0;

    logic [DATA_W-1:0] model_q [$];
    int                prim_acc = 0;
    logic              exp_ov = 1'b0;

    fir_tap_buffer #(
        .DATA_W (DATA_W),
        .TAPS   (TAPS),
        .DECIM  (DECIM)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .enable    (enable),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .taps      (taps),
        .fill      (fill),
        .primed    (primed),
        .out_valid (out_valid)
    );

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [63:0] model_taps();
        logic [63:0] v;
        v = '0;
        for (int k = 0; k < model_q.size(); k++) begin
            v[k*DATA_W +: DATA_W] = model_q[k];
        end
        return v;
    endfunction

    task automatic model_clear();
        model_q.delete();
        prim_acc = 0;
        exp_ov   = 1'b0;
    endtask

    // Newest sample lives at the front of the queue; a full queue is a full tap vector.
    task automatic model_step(input logic en, input logic fl, input logic vld, input logic [DATA_W-1:0] d);
        exp_ov = 1'b0;
        if (fl) begin
            model_clear();
        end else if (en && vld) begin
            model_q.push_front(d);
            if (model_q.size() > TAPS) void'(model_q.pop_back());
            if (model_q.size() == TAPS) begin
`ifdef FIR_TAP_BUFFER_DECIM_EN
                exp_ov = ((prim_acc % DECIM) == 0);
`else
                exp_ov = 1'b1;
`endif
                prim_acc++;
            end
        end
    endtask

    task automatic check_model();
        checkOutput("taps", taps, model_taps());
        checkOutput("fill", fill, model_q.size());
        checkOutput("primed", primed, model_q.size() == TAPS);
        checkOutput("out_valid", out_valid, exp_ov);
        if (out_valid === 1'b1) pulse_cnt++;
    endtask

    task automatic applyStimulus(input logic en, input logic fl, input logic vld, input logic [DATA_W-1:0] d);
        enable   = en;
        flush    = fl;
        in_valid = vld;
        in_data  = d;
        #1;
        checkOutput("in_ready", in_ready, en && !fl);
        @(posedge clk);
        model_step(en, fl, vld, d);
        #1;
        check_model();
    endtask

    initial begin
        logic en, fl, vld;

        resetn   = 1'b0;
        enable   = 1'b1;
        flush    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        #2;
        checkOutput("rst_taps", taps, 64'h0);
        checkOutput("rst_fill", fill, 0);
        checkOutput("rst_primed", primed, 1'b0);
        checkOutput("rst_out_valid", out_valid, 1'b0);
        checkOutput("rst_in_ready", in_ready, 1'b0);

        clk_run = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        resetn = 1'b1;
        model_clear();

        pulse_cnt = 0;
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, DATA_W'(i));
            checkOutput("fill_ramp", fill, i);
        end
        checkOutput("prime_pulses", pulse_cnt, 1);
        checkOutput("prime_taps", taps, 64'h0102030405060708);
        checkOutput("prime_primed", primed, 1'b1);

        pulse_cnt = 0;
        applyStimulus(1'b1, 1'b0, 1'b1, 8'd9);
        checkOutput("tap0_after9", taps[7:0], 9);
        checkOutput("tap7_after9", taps[63:56], 2);
        checkOutput("fill_after9", fill, 8);
`ifdef FIR_TAP_BUFFER_DECIM_EN
        checkOutput("pulses_after9", pulse_cnt, 0);
`else
        checkOutput("pulses_after9", pulse_cnt, 1);
`endif

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, DATA_W'($urandom));
            checkOutput("hold_taps", taps, 64'h0203040506070809);
            checkOutput("hold_fill", fill, 8);
        end

        applyStimulus(1'b1, 1'b1, 1'b1, 8'h55);
        checkOutput("flush_taps", taps, 64'h0);
        checkOutput("flush_fill", fill, 0);

        pulse_cnt = 0;
        for (int i = 1; i <= 12; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, DATA_W'($urandom));
        end
`ifdef FIR_TAP_BUFFER_DECIM_EN
        checkOutput("pulses_12", pulse_cnt, 3);
`else
        checkOutput("pulses_12", pulse_cnt, 5);
`endif

        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, DATA_W'($urandom));
        end
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("midrst_taps", taps, 64'h0);
        checkOutput("midrst_fill", fill, 0);
        checkOutput("midrst_in_ready", in_ready, 1'b0);
        checkOutput("midrst_out_valid", out_valid, 1'b0);
        model_clear();
        @(posedge clk);
        #2;
        resetn = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h3C);
        applyStimulus(1'b1, 1'b0, 1'b1, 8'hC3);
        checkOutput("refill_fill", fill, 2);
        checkOutput("refill_taps", taps, 64'h3CC3);

        for (int i = 0; i < 400; i++) begin
            en  = ($urandom_range(0, 9) != 0);
            fl  = en && ($urandom_range(0, 39) == 0);
            vld = ($urandom_range(0, 3) != 0);
            applyStimulus(en, fl, vld, DATA_W'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fir_tap_buffer.md
FIR_TAP_BUFFER -- requirements
Module: fir_tap_buffer

Interface
- REQ-001: Parameter DATA_W, default 8, SHALL set the sample width in bits (legal 1..32).
- REQ-002: Parameter TAPS, default 8, SHALL set the number of tap registers (legal 2..64).
- REQ-003: Parameter DECIM, default 2, SHALL set the decimation ratio (legal 1..16); it is used only when FIR_TAP_BUFFER_DECIM_EN is defined.
- REQ-004: Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
- REQ-005: Port resetn, input, 1 bit, SHALL be the asynchronous, active-low reset.
- REQ-006: Port enable, input, 1 bit, SHALL be the global run qualifier.
- REQ-007: Port flush, input, 1 bit, SHALL be the synchronous clear request.
- REQ-008: Port in_valid, input, 1 bit, SHALL mark in_data as valid.
- REQ-009: Port in_data, input, DATA_W bits, SHALL carry the new sample.
- REQ-010: Port in_ready, output, 1 bit, SHALL equal enable AND NOT flush AND resetn (combinational).
- REQ-011: Port taps, output, TAPS*DATA_W bits, SHALL carry tap k at bits [k*DATA_W +: DATA_W]; tap 0 holds the newest sample.
- REQ-012: Port fill, output, clog2(TAPS+1) bits, SHALL carry the count of valid samples held.
- REQ-013: Port primed, output, 1 bit, SHALL be high when fill == TAPS.
- REQ-014: Port out_valid, output, 1 bit, SHALL be a registered one-cycle pulse marking a tap vector ready for the MAC stage.

Function
- REQ-015: Accept SHALL occur on a rising clk edge where in_valid AND in_ready are both high.
- REQ-016: On accept, tap 0 SHALL load in_data and tap k SHALL load tap k-1 for k = 1..TAPS-1; the sample SHALL be visible on tap 0 one cycle after the accept.
- REQ-017: On accept, fill SHALL increment and saturate at TAPS; after saturation the oldest sample is discarded.
- REQ-018: State SHALL be EMPTY (fill=0), FILLING (0<fill<TAPS) or PRIMED (fill=TAPS): EMPTY->FILLING on accept; FILLING->PRIMED on the accept that reaches TAPS; any state->EMPTY on flush.
- REQ-019: out_valid SHALL pulse high for exactly one cycle, the cycle after any accept that leaves the state PRIMED; it SHALL be low in all other cycles.
- REQ-020: With enable low, taps, fill, state and the phase counter SHALL hold, and out_valid SHALL be 0.
- REQ-021: flush high SHALL clear taps to 0, fill to 0, state to EMPTY, the phase counter to 0 and out_valid to 0 on the next edge; no accept occurs in that cycle.
- REQ-022: The block SHALL perform no arithmetic on data; samples SHALL pass through bit-exact.

Reset
- REQ-023: While resetn is low, SHALL hold taps=0, fill=0, primed=0, out_valid=0, in_ready=0, state=EMPTY and phase=0, independent of clk.
- REQ-024: Reset assertion mid-fill SHALL discard all held samples; refill SHALL restart from EMPTY after deassertion.

Configuration
- REQ-025: With FIR_TAP_BUFFER_DECIM_EN defined, a phase counter of range 0..DECIM-1 SHALL advance, wrapping, on each accept in PRIMED state; out_valid SHALL pulse only for accepts where phase was 0 before the advance.
- REQ-026: With FIR_TAP_BUFFER_DECIM_EN undefined, no phase counter SHALL exist, DECIM SHALL be ignored, and REQ-019 SHALL apply unmodified.

Verification
- REQ-027: Scenario: resetn=0 asserted with clk stopped -> all outputs at their reset values immediately.
- REQ-028: Scenario: TAPS=8, DATA_W=8, accept samples 1..8 back-to-back -> fill goes 1..8, primed=1, out_valid pulses once, tap0..tap7 = 8,7,...,1.
- REQ-029: Scenario: after the priming scenario, accept 9 -> tap0=9, tap7=2, fill stays 8, one out_valid pulse.
- REQ-030: Scenario: flush=1 with in_valid=1 and data 0x55 -> in_ready=0, taps all 0, fill=0 on the next cycle, no out_valid.
- REQ-031: Scenario: enable=0 for 3 cycles with in_valid=1 -> in_ready=0, taps and fill unchanged, out_valid=0.
- REQ-032: Scenario: DECIM=2, accept 12 samples -> with the macro defined, out_valid pulses after accepts 8, 10 and 12 (3 pulses); undefined, after accepts 8 to 12 (5 pulses).
